conv_frame_loader: RTL and testbench

- Upstream feeder for the 4x4-image / 3x3-kernel systolic convolution array.
- Accepts a byte stream over a valid/ready handshake: 16 image bytes, then 9 kernel bytes.
- Deserialises the stream into registered parallel operands a11..a44 and b11..b33.
- Asserts out_valid and holds the operands stable until the array acknowledges with out_ack, then loads the next frame.

---
 rtl/conv_frame_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_conv_frame_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_loader.sv
// -----------------------------------------------------------------------------
// conv_frame_loader
//
// Upstream feeder for the 4x4-image / 3x3-kernel systolic convolution array.
// A byte stream (16 image bytes then 9 kernel bytes, both row-major) arrives
// over a valid/ready handshake. It is deserialised into registered parallel
// operands. The full frame is then presented with out_valid until out_ack.
//
// Optional build macro: CONV_KERNEL_REUSE_EN
//   When defined, the kernel_reload input exists. After the first full frame,
//   a frame may consist of only 16 image bytes and reuse the held kernel,
//   unless kernel_reload was high on the acknowledging edge.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   kernel_reload  (CONV_KERNEL_REUSE_EN only) reload kernel on next frame,
//                  sampled on the out_ack edge
//   in_valid       upstream byte valid
//   in_data        upstream byte
//   in_ready       loader can accept a byte (registered)
//   a11..a44       image operands, aRC = row R, column C
//   b11..b33       kernel operands, bRC = row R, column C
//   out_valid      full frame held on a*/b*
//   out_ack        array has consumed the frame
//   frame_cnt      frames acknowledged, wraps modulo 256
// -----------------------------------------------------------------------------
module conv_frame_loader #(
  parameter int DW    = 8,
  parameter int IMG_N = 16,
  parameter int KER_N = 9
) (
  input  logic          clk,
  input  logic          rst,
`ifdef CONV_KERNEL_REUSE_EN
  input  logic          kernel_reload,
`endif
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] a11,
  output logic [DW-1:0] a12,
  output logic [DW-1:0] a13,
  output logic [DW-1:0] a14,
  output logic [DW-1:0] a21,
  output logic [DW-1:0] a22,
  output logic [DW-1:0] a23,
  output logic [DW-1:0] a24,
  output logic [DW-1:0] a31,
  output logic [DW-1:0] a32,
  output logic [DW-1:0] a33,
  output logic [DW-1:0] a34,
  output logic [DW-1:0] a41,
  output logic [DW-1:0] a42,
  output logic [DW-1:0] a43,
  output logic [DW-1:0] a44,
  output logic [DW-1:0] b11,
  output logic [DW-1:0] b12,
  output logic [DW-1:0] b13,
  output logic [DW-1:0] b21,
  output logic [DW-1:0] b22,
  output logic [DW-1:0] b23,
  output logic [DW-1:0] b31,
  output logic [DW-1:0] b32,
  output logic [DW-1:0] b33,
  output logic          out_valid,
  input  logic          out_ack,
  output logic [7:0]    frame_cnt
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_e;

  localparam logic [4:0] IMG_LAST = 5'(IMG_N - 1);
  localparam logic [4:0] KER_LAST = 5'(KER_N - 1);

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]   a_q [IMG_N];
  logic [DW-1:0]   a_d [IMG_N];
  logic [DW-1:0]   b_q [KER_N];
  logic [DW-1:0]   b_d [KER_N];

  // in_ready is registered, so it alone gates every transfer.
  logic            xfer;
  logic            skip_kernel;

  assign xfer = in_valid && in_ready_q;

`ifdef CONV_KERNEL_REUSE_EN
  // ker_valid_q: a kernel has been loaded since reset.
  // skip_q: the current frame reuses the held kernel (decided on the ack edge).
  logic ker_valid_q, ker_valid_d;
  logic skip_q, skip_d;

  assign skip_kernel = skip_q;

  always_comb begin
    ker_valid_d = ker_valid_q;
    skip_d      = skip_q;
    if (state_q == LOAD_B && xfer && cnt_q == KER_LAST) begin
      ker_valid_d = 1'b1;
    end
    if (state_q == PRESENT && out_ack) begin
      skip_d = ker_valid_q && !kernel_reload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ker_valid_q <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      ker_valid_q <= ker_valid_d;
      skip_q      <= skip_d;
    end
  end
`else
  assign skip_kernel = 1'b0;
`endif

  // State register together with the counter, handshake flags and operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  // Next-state logic: byte counter sequencing and frame acknowledgement.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      LOAD_A: begin
        if (xfer) begin
          if (cnt_q == IMG_LAST) begin
            cnt_d   = '0;
            state_d = skip_kernel ? PRESENT : LOAD_B;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          if (cnt_q == KER_LAST) begin
            cnt_d   = '0;
            state_d = PRESENT;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      PRESENT: begin
        if (out_ack) begin
          state_d     = LOAD_A;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: handshake flags are registered copies of the next state,
  // so out_valid rises on the same edge that captures the last byte.
  always_comb begin
    in_ready_d  = (state_d != PRESENT);
    out_valid_d = (state_d == PRESENT);
  end

  // Operand capture: only the register addressed by cnt changes, so stale
  // values from the previous frame stay visible during a partial load.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (xfer && state_q == LOAD_A) begin
      for (int i = 0; i < IMG_N; i++) begin
        if (cnt_q == 5'(i)) a_d[i] = in_data;
      end
    end
    if (xfer && state_q == LOAD_B) begin
      for (int i = 0; i < KER_N; i++) begin
        if (cnt_q == 5'(i)) b_d[i] = in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;

  assign a11 = a_q[0];
  assign a12 = a_q[1];
  assign a13 = a_q[2];
  assign a14 = a_q[3];
  assign a21 = a_q[4];
  assign a22 = a_q[5];
  assign a23 = a_q[6];
  assign a24 = a_q[7];
  assign a31 = a_q[8];
  assign a32 = a_q[9];
  assign a33 = a_q[10];
  assign a34 = a_q[11];
  assign a41 = a_q[12];
  assign a42 = a_q[13];
  assign a43 = a_q[14];
  assign a44 = a_q[15];

  assign b11 = b_q[0];
  assign b12 = b_q[1];
  assign b13 = b_q[2];
  assign b21 = b_q[3];
  assign b22 = b_q[4];
  assign b23 = b_q[5];
  assign b31 = b_q[6];
  assign b32 = b_q[7];
  assign b33 = b_q[8];

endmodule

// File: tb/tb_conv_frame_loader.sv
module tb_conv_frame_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ack;
  logic [7:0] frame_cnt;
`ifdef CONV_KERNEL_REUSE_EN
  logic       kernel_reload;
`endif
  logic [7:0] a11, a12, a13, a14, a21, a22, a23, a24;
  logic [7:0] a31, a32, a33, a34, a41, a42, a43, a44;
  logic [7:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;

  conv_frame_loader #(.DW(8), .IMG_N(16), .KER_N(9)) dut (
    .clk(clk), .rst(rst),
`ifdef CONV_KERNEL_REUSE_EN
    .kernel_reload(kernel_reload),
`endif
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .a11(a11), .a12(a12), .a13(a13), .a14(a14),
    .a21(a21), .a22(a22), .a23(a23), .a24(a24),
    .a31(a31), .a32(a32), .a33(a33), .a34(a34),
    .a41(a41), .a42(a42), .a43(a43), .a44(a44),
    .b11(b11), .b12(b12), .b13(b13),
    .b21(b21), .b22(b22), .b23(b23),
    .b31(b31), .b32(b32), .b33(b33),
    .out_valid(out_valid), .out_ack(out_ack), .frame_cnt(frame_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the operand registers and the frame counter.
  logic [7:0]   m_a [16];
  logic [7:0]   m_b [9];
  logic [7:0]   exp_cnt;
  logic [199:0] sb_q [$];
  logic [199:0] got;
  logic [199:0] exp_v;

  function automatic logic [199:0] dut_ops();
    return {a11, a12, a13, a14, a21, a22, a23, a24,
            a31, a32, a33, a34, a41, a42, a43, a44,
            b11, b12, b13, b21, b22, b23, b31, b32, b33};
  endfunction

  function automatic logic [199:0] model_vec();
    logic [199:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[199-8*i -: 8] = m_a[i];
    for (int i = 0; i < 9; i++)  v[71-8*i -: 8]  = m_b[i];
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_a[i] = 8'h00;
    for (int i = 0; i < 9; i++)  m_b[i] = 8'h00;
    exp_cnt = 8'h00;
    sb_q.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] v);
    int n;
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends frame byte indices first..last (0..15 image, 16..24 kernel) and
  // pushes the expected operand set once index end_idx has been sent.
  task automatic stream(input int img_base, input int ker_base, input int first,
                        input int last, input int end_idx, input bit gap);
    logic [7:0] v;
    for (int idx = first; idx <= last; idx++) begin
      if (idx < 16) begin
        v = 8'(img_base + idx);
        m_a[idx] = v;
      end else begin
        v = 8'(ker_base + idx - 16);
        m_b[idx-16] = v;
      end
      send_byte(v);
      if (idx == end_idx) sb_q.push_back(model_vec());
      if (gap) @(negedge clk);
    end
  endtask

  task automatic do_ack();
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (dut_ops() !== '0) begin bad++; $display("FAIL rst_ops got=%h req=0", dut_ops()); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b req=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b req=0", in_ready); end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL rst_frame_cnt got=%0d req=0", frame_cnt); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b req=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_release_out_valid got=%b req=0", out_valid); end
  endtask

  task automatic test_basic_frame();
    stream(1, 17, 0, 23, 24, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b req=0", out_valid); end
    stream(1, 17, 24, 24, 24, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b req=1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready got=%b req=0", in_ready); end
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL basic_sb_empty got=0 req=1"); end
    else begin
      exp_v = sb_q.pop_front();
      got = dut_ops();
      if (got !== exp_v) begin bad++; $display("FAIL basic_ops got=%h req=%h", got, exp_v); end
    end
    total++; if (a11 !== 8'd1) begin bad++; $display("FAIL basic_a11 got=%0d req=1", a11); end
    total++; if (a14 !== 8'd4) begin bad++; $display("FAIL basic_a14 got=%0d req=4", a14); end
    total++; if (a44 !== 8'd16) begin bad++; $display("FAIL basic_a44 got=%0d req=16", a44); end
    total++; if (b11 !== 8'd17) begin bad++; $display("FAIL basic_b11 got=%0d req=17", b11); end
    total++; if (b33 !== 8'd25) begin bad++; $display("FAIL basic_b33 got=%0d req=25", b33); end
  endtask

  task automatic test_holdoff();
    exp_v = model_vec();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (5) @(negedge clk);
    got = dut_ops();
    total++; if (got !== exp_v) begin bad++; $display("FAIL hold_ops got=%h req=%h", got, exp_v); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready got=%b req=0", in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_out_valid got=%b req=1", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_ack_second();
    do_ack();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ack_out_valid got=%b req=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ack_in_ready got=%b req=1", in_ready); end
    total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL ack_frame_cnt got=%0d req=%0d", frame_cnt, exp_cnt); end
    stream(101, 117, 0, 24, 24, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL second_valid got=%b req=1", out_valid); end
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL second_sb_empty got=0 req=1"); end
    else begin
      exp_v = sb_q.pop_front();
      got = dut_ops();
      if (got !== exp_v) begin bad++; $display("FAIL second_ops got=%h req=%h", got, exp_v); end
    end
    total++; if (a11 !== 8'd101) begin bad++; $display("FAIL second_a11 got=%0d req=101", a11); end
    total++; if (b33 !== 8'd125) begin bad++; $display("FAIL second_b33 got=%0d req=125", b33); end
    do_ack();
    total++; if (frame_cnt !== 8'd2) begin bad++; $display("FAIL second_frame_cnt got=%0d req=2", frame_cnt); end
  endtask

  task automatic test_toggle_early_ack();
    stream(40, 60, 0, 7, 24, 1);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL early_ack_cnt got=%0d req=%0d", frame_cnt, exp_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL early_ack_in_ready got=%b req=1", in_ready); end
    got = dut_ops();
    exp_v = model_vec();
    total++; if (got !== exp_v) begin bad++; $display("FAIL partial_stale got=%h req=%h", got, exp_v); end
    stream(40, 60, 8, 24, 24, 1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL toggle_valid got=%b req=1", out_valid); end
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL toggle_sb_empty got=0 req=1"); end
    else begin
      exp_v = sb_q.pop_front();
      got = dut_ops();
      if (got !== exp_v) begin bad++; $display("FAIL toggle_ops got=%h req=%h", got, exp_v); end
    end
    do_ack();
    total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL toggle_frame_cnt got=%0d req=%0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_mid_reset();
    stream(200, 0, 0, 9, 24, 0);
    #2;
    rst = 1'b1;
    #1;
    total++; if (dut_ops() !== '0) begin bad++; $display("FAIL midrst_ops got=%h req=0", dut_ops()); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b req=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b req=0", in_ready); end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL midrst_frame_cnt got=%0d req=0", frame_cnt); end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_release got=%b req=1", in_ready); end
    stream(10, 30, 0, 24, 24, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_valid got=%b req=1", out_valid); end
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL midrst_sb_empty got=0 req=1"); end
    else begin
      exp_v = sb_q.pop_front();
      got = dut_ops();
      if (got !== exp_v) begin bad++; $display("FAIL midrst_ops_frame got=%h req=%h", got, exp_v); end
    end
    total++; if (a11 !== 8'd10) begin bad++; $display("FAIL midrst_a11 got=%0d req=10", a11); end
    do_ack();
    total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL midrst_frame_cnt_ack got=%0d req=1", frame_cnt); end
  endtask

`ifdef CONV_KERNEL_REUSE_EN
  task automatic test_kernel_reuse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    stream(50, 1, 0, 24, 24, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL reuse_f1_valid got=%b req=1", out_valid); end
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL reuse_f1_sb_empty got=0 req=1"); end
    else begin
      exp_v = sb_q.pop_front();
      got = dut_ops();
      if (got !== exp_v) begin bad++; $display("FAIL reuse_f1_ops got=%h req=%h", got, exp_v); end
    end
    total++; if (b33 !== 8'd9) begin bad++; $display("FAIL reuse_f1_b33 got=%0d req=9", b33); end
    kernel_reload = 1'b0;
    do_ack();
    kernel_reload = 1'b1;
    stream(70, 0, 0, 15, 15, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL reuse_skip_valid got=%b req=1", out_valid); end
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL reuse_skip_sb_empty got=0 req=1"); end
    else begin
      exp_v = sb_q.pop_front();
      got = dut_ops();
      if (got !== exp_v) begin bad++; $display("FAIL reuse_skip_ops got=%h req=%h", got, exp_v); end
    end
    total++; if (b33 !== 8'd9) begin bad++; $display("FAIL reuse_skip_b33 got=%0d req=9", b33); end
    do_ack();
    stream(90, 5, 0, 15, 24, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reuse_reload_early got=%b req=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reuse_reload_ready got=%b req=1", in_ready); end
    stream(90, 5, 16, 24, 24, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL reuse_reload_valid got=%b req=1", out_valid); end
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL reuse_reload_sb_empty got=0 req=1"); end
    else begin
      exp_v = sb_q.pop_front();
      got = dut_ops();
      if (got !== exp_v) begin bad++; $display("FAIL reuse_reload_ops got=%h req=%h", got, exp_v); end
    end
    total++; if (b33 !== 8'd13) begin bad++; $display("FAIL reuse_reload_b33 got=%0d req=13", b33); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    out_ack  = 1'b0;
`ifdef CONV_KERNEL_REUSE_EN
    kernel_reload = 1'b1;
`endif
    clear_model();
    test_reset();
    test_basic_frame();
    test_holdoff();
    test_ack_second();
    test_toggle_early_ack();
    test_mid_reset();
`ifdef CONV_KERNEL_REUSE_EN
    test_kernel_reuse();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
